// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, sample type and bit-reversal helper.
package fft_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int LOG2_N = 6;
  localparam int N = 2 ** LOG2_N;
  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } sample_t;
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) r[i] = value[width-1-i];
    return r;
  endfunction
endpackage

// File: rtl/reorder_dpram.sv
// reorder_dpram: one write port, one combinational read port, 2**AW entries.
module reorder_dpram #(
  parameter int AW = 7,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed DIF frames into natural order.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
  parameter int LOG2_N = fft_pkg::LOG2_N
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic signed [DATA_WIDTH-1:0] din_real,
  input  logic signed [DATA_WIDTH-1:0] din_imag,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic signed [DATA_WIDTH-1:0] dout_real,
  output logic signed [DATA_WIDTH-1:0] dout_imag,
  output logic                         dout_last,
  output logic                         ovf_err
);
  localparam logic [LOG2_N-1:0] LAST = '1;
  logic [LOG2_N-1:0] wr_cnt, rd_cnt, wr_idx;
  logic wr_bank, rd_bank, wr_en, load;
  logic [1:0] full;
  logic [2*DATA_WIDTH-1:0] rd_data;
  assign din_ready = rst_n && !full[wr_bank];
  assign wr_en = din_valid && din_ready;
  assign load = full[rd_bank] && (!dout_valid || dout_ready);
  assign wr_idx = LOG2_N'(bitrev(32'(wr_cnt), LOG2_N));
  reorder_dpram #(.AW(LOG2_N + 1), .DW(2 * DATA_WIDTH)) u_mem (
    .clk,
    .we(wr_en),
    .waddr({wr_bank, wr_idx}),
    .wdata({din_real, din_imag}),
    .raddr({rd_bank, rd_cnt}),
    .rdata(rd_data)
  );
  // Write and read banks never coincide while both are active, so the two full updates never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full <= '0;
      dout_valid <= 1'b0;
      dout_real <= '0;
      dout_imag <= '0;
      dout_last <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LAST) begin
          full[wr_bank] <= 1'b1;
          wr_bank <= ~wr_bank;
        end
      end
      if (load) begin
        {dout_real, dout_imag} <= rd_data;
        dout_valid <= 1'b1;
        dout_last <= rd_cnt == LAST;
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == LAST) begin
          full[rd_bank] <= 1'b0;
          rd_bank <= ~rd_bank;
        end
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
        dout_last <= 1'b0;
      end
      if (din_valid && !din_ready) ovf_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: directed checks of the bit-reverse reorder buffer with N=8.
module tb_fft_bitrev_reorder;
  logic clk = 0;
  logic rst_n, din_valid, din_ready, dout_valid, dout_ready, dout_last, ovf_err;
  logic signed [11:0] din_real, din_imag, dout_real, dout_imag;
  int checks = 0, errors = 0, pops = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
  logic [24:0] exp_q[$];
  logic [23:0] fr[8];
  fft_bitrev_reorder #(.DATA_WIDTH(12), .LOG2_N(3)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready),
    .din_real(din_real), .din_imag(din_imag), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_real(dout_real), .dout_imag(dout_imag),
    .dout_last(dout_last), .ovf_err(ovf_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] rev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction
  task automatic send(input logic [23:0] v[8], input int cnt, input int gap);
    for (int k = 0; k < cnt; k++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) @(posedge clk);
      @(negedge clk);
      for (int t = 0; !din_ready; t++) begin
        if (t == 500) begin
          $display("FAIL in_timeout got %0d exp 0", t);
          $fatal(1);
        end
        @(negedge clk);
      end
      din_valid = 1;
      {din_real, din_imag} = v[k];
      @(posedge clk);
      #1 din_valid = 0;
    end
    if (cnt == 8)
      for (int n = 0; n < 8; n++) exp_q.push_back({n == 7, v[rev3(3'(n))]});
  endtask
  task automatic drain();
    int t;
    for (t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    #1 check("drain", 32'(exp_q.size()), 32'd0);
  endtask
  // Output scoreboard: pops on each handshake and checks dout_* hold while stalled.
  initial begin
    logic stalled;
    logic [24:0] held, e;
    stalled = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (stalled) check("hold", 32'({dout_valid, dout_last, dout_real, dout_imag}), 32'({1'b1, held}));
      stalled = rst_n && dout_valid && !dout_ready;
      held = {dout_last, dout_real, dout_imag};
      if (rst_n && dout_valid && dout_ready) begin
        if (exp_q.size() == 0) check("unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("dout", 32'({dout_last, dout_real, dout_imag}), 32'(e));
          if (pops == 0) first_cyc = cyc;
          last_cyc = cyc;
          pops++;
        end
      end
    end
  end
  initial begin
    #2_000_000 $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    rst_n = 0; din_valid = 0; din_real = 0; din_imag = 0; dout_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_din_ready", 32'(din_ready), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_data", 32'({dout_last, dout_real, dout_imag}), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    rst_n = 1;
    #1 check("din_ready_up", 32'(din_ready), 32'd1);
    // Frame 0..7: expect 0,4,2,6,1,5,3,7 with 2-cycle latency
    for (int k = 0; k < 8; k++) fr[k] = {12'(k), 12'(k + 12'h100)};
    send(fr, 8, 0);
    check("lat_e", 32'(dout_valid), 32'd0);
    @(posedge clk);
    #1 check("lat_e1", 32'(dout_valid), 32'd1);
    check("first_out", 32'({dout_last, dout_real, dout_imag}), 32'({1'b0, 12'd0, 12'h100}));
    drain();
    // Back-to-back frames with no output bubble
    pops = 0;
    for (int k = 0; k < 8; k++) fr[k] = {12'(k), -12'(k)};
    send(fr, 8, 0);
    for (int k = 0; k < 8; k++) fr[k] = {12'(k + 8), -12'(k + 8)};
    send(fr, 8, 0);
    drain();
    check("b2b_count", 32'(pops), 32'd16);
    check("b2b_span", 32'(last_cyc - first_cyc), 32'd15);
    // Stall output: both banks fill, then overflow
    dout_ready = 0;
    for (int k = 0; k < 8; k++) fr[k] = {12'(k * 3), 12'(k * 5)};
    send(fr, 8, 0);
    for (int k = 0; k < 8; k++) fr[k] = {12'(k * 7), 12'(k * 11)};
    send(fr, 8, 0);
    @(negedge clk);
    check("full_din_ready", 32'(din_ready), 32'd0);
    check("ovf_before", 32'(ovf_err), 32'd0);
    din_valid = 1;
    @(posedge clk);
    #1 din_valid = 0;
    check("ovf_set", 32'(ovf_err), 32'd1);
    dout_ready = 1;
    repeat (6) @(posedge clk);
    #1 check("rdy_still_low", 32'(din_ready), 32'd0);
    @(posedge clk);
    #1 check("rdy_after_idx7", 32'(din_ready), 32'd1);
    drain();
    check("ovf_sticky", 32'(ovf_err), 32'd1);
    // Toggle dout_ready 1010... during a read
    for (int k = 0; k < 8; k++) fr[k] = {12'(12'h7f0 + k), 12'(12'h805 - k)};
    send(fr, 8, 0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 dout_ready = ~dout_ready;
    end
    dout_ready = 1;
    drain();
    // Reset after 5 of 8 samples discards everything
    for (int k = 0; k < 8; k++) fr[k] = {12'(12'h0a0 + k), 12'(12'h050 + k)};
    send(fr, 5, 0);
    @(negedge clk);
    rst_n = 0;
    #1 check("rst_mid_ready", 32'(din_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_data", 32'({dout_valid, dout_last, dout_real, dout_imag}), 32'd0);
    check("rst_mid_ovf", 32'(ovf_err), 32'd0);
    rst_n = 1;
    #1 check("rst_mid_ready_up", 32'(din_ready), 32'd1);
    for (int k = 0; k < 8; k++) fr[k] = {12'(12'h3c0 + k), 12'(12'hc30 + k)};
    send(fr, 8, 0);
    drain();
    // Random values with input gaps and random output stalls
    fork
      for (int f = 0; f < 3; f++) begin
        logic [23:0] rv[8];
        for (int k = 0; k < 8; k++) rv[k] = 24'($urandom);
        send(rv, 8, 3);
      end
      for (int i = 0; i < 120; i++) begin
        @(posedge clk);
        #1 dout_ready = 1'($urandom_range(0, 1));
      end
    join
    dout_ready = 1;
    drain();
    check("ovf_final", 32'(ovf_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
